router_in_arb: RTL

- Packet-level round-robin arbiter placed in front of router_top's single ingress port. NUM_SRC sources share that port.
- The arbiter grants one source for a whole packet. It forwards header, payload and parity bytes using the router protocol: pkt_valid is high for header and payload, and low for the parity byte.
- It honours router busy, drops packets with an illegal address (2'b11), and keeps saturating error and drop counters.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_rr_pick.sv | 34 +++
 rtl/router_in_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router ingress/egress arbiters.
// Holds the arbiter state encoding, the illegal destination address and
// the bit positions of the header fields (length in [7:2], address in [1:0]).
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    DROP,
    GAP
  } state_t;

  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at rr_ptr+1 upward with wrap-around and returns the
// first requester as a one-hot winner.
//   req    : request vector, one bit per source
//   rr_ptr : index of the source that was served last
//   winner : one-hot winning source (all zero when nothing requests)
//   valid  : at least one request present
module router_rr_pick #(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] rr_ptr,
  output logic [NUM_SRC-1:0]         winner,
  output logic                       valid
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = PTR_W'((32'(rr_ptr) + off) % NUM_SRC);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_in_arb.sv
// Packet-level round-robin arbiter in front of the router's single ingress.
// One source owns the port for a whole packet (header, payload, parity).
// Packets addressed to ADDR_ILLEGAL are consumed and discarded.
//   clk, resetn     : clock, synchronous active-low reset
//   src_req         : per-source packet request
//   src_data        : per-source byte, source i in [8i+7:8i]
//   src_ack         : per-source byte consumed this cycle
//   grant           : registered one-hot owner of the ingress port
//   rtr_data        : byte to router data_in
//   rtr_pkt_valid   : high for header/payload, low for parity
//   rtr_busy        : router stall
//   rtr_err         : router error flag
//   arb_active      : arbiter is not idle
//   err_cnt         : saturating count of rtr_err rising edges
//   drop_cnt        : saturating count of dropped packets
module router_in_arb
  import router_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_ack,
  output logic [NUM_SRC-1:0]   grant,
  output logic [7:0]           rtr_data,
  output logic                 rtr_pkt_valid,
  input  logic                 rtr_busy,
  input  logic                 rtr_err,
  output logic                 arb_active,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  state_t             state, state_d;
  logic [NUM_SRC-1:0] grant_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d, g_idx;
  logic [6:0]         cnt, cnt_d;
  logic               drop_inc;
  logic               err_q;
  logic [7:0]         cur_byte;
  logic [5:0]         hdr_len;
  logic               hdr_illegal;
  logic [NUM_SRC-1:0] pick;
  logic               pick_valid;

  router_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req    (src_req),
    .rr_ptr (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
    end
  end

  assign cur_byte    = src_data[32'(g_idx)*8 +: 8];
  assign hdr_len     = cur_byte[LEN_MSB:LEN_LSB];
  assign hdr_illegal = (cur_byte[ADDR_MSB:ADDR_LSB] == ADDR_ILLEGAL);
  assign arb_active  = (state != IDLE);

  always_comb begin
    state_d       = state;
    grant_d       = grant;
    rr_ptr_d      = rr_ptr;
    cnt_d         = cnt;
    drop_inc      = 1'b0;
    src_ack       = '0;
    rtr_data      = '0;
    rtr_pkt_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (hdr_illegal) begin
          // Dropped header is swallowed without waiting on the router.
          src_ack  = grant;
          cnt_d    = {1'b0, hdr_len} + 7'd1;
          drop_inc = 1'b1;
          state_d  = DROP;
        end else begin
          rtr_data      = cur_byte;
          rtr_pkt_valid = 1'b1;
          if (!rtr_busy) begin
            src_ack = grant;
            cnt_d   = {1'b0, hdr_len};
            state_d = (hdr_len == 6'd0) ? PARITY : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        rtr_data      = cur_byte;
        rtr_pkt_valid = 1'b1;
        if (!rtr_busy) begin
          src_ack = grant;
          cnt_d   = cnt - 7'd1;
          if (cnt == 7'd1) state_d = PARITY;
        end
      end
      PARITY: begin
        rtr_data = cur_byte;
        if (!rtr_busy) begin
          src_ack = grant;
          state_d = GAP;
        end
      end
      DROP: begin
        src_ack = grant;
        cnt_d   = cnt - 7'd1;
        if (cnt == 7'd1) state_d = GAP;
      end
      GAP: begin
        rr_ptr_d = g_idx;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= PTR_W'(NUM_SRC - 1);
      cnt      <= '0;
      err_q    <= 1'b0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      rr_ptr <= rr_ptr_d;
      cnt    <= cnt_d;
      err_q  <= rtr_err;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (rtr_err && !err_q && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
